z80fi_insn_packer: RTL and testbench

Builds the Z80 formal-interface (z80fi) retirement record that the per-instruction spec modules consume. It sits inside the core next to the sequencer and observes instruction-start pulses, opcode-byte fetches and the architectural register file. At each instruction boundary it emits one `z80fi_valid` pulse carrying the opcode bytes, the instruction length, and the register values captured before and after the instruction.

---
 rtl/z80fi_insn_packer_pkg.sv | 32 +++
 rtl/z80fi_insn_packer_if.sv | 60 ++++++
 rtl/z80fi_insn_byte_collector.sv | 51 +++++
 rtl/z80fi_insn_packer.sv | 131 +++++++++++++
 tb/tb_z80fi_insn_packer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/z80fi_insn_packer_pkg.sv
// Shared types for the z80fi retirement-record packer: register-pair indices,
// register snapshot struct and FSM state. Honours Z80FI_PACKER_ALT_REGS_EN.
package z80fi_pkg;

  localparam int REG_BC = 0;
  localparam int REG_DE = 1;
  localparam int REG_HL = 2;
  localparam int REG_SP = 3;

  typedef struct packed {
    logic [15:0] ip;
    logic [15:0] af;
    logic [15:0] bc;
    logic [15:0] de;
    logic [15:0] hl;
    logic [15:0] ix;
    logic [15:0] iy;
    logic [15:0] sp;
`ifdef Z80FI_PACKER_ALT_REGS_EN
    logic [15:0] af2;
    logic [15:0] bc2;
    logic [15:0] de2;
    logic [15:0] hl2;
`endif
  } z80fi_regs_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } z80fi_state_t;

endpackage

// File: rtl/z80fi_insn_packer_if.sv
// Sequencer-side observation signals and the emitted z80fi record.
// Alternate register set present only with Z80FI_PACKER_ALT_REGS_EN.
interface z80fi_insn_packer_if #(
  parameter int MAX_LEN = 4
);
  logic                   insn_start;
  logic                   insn_byte_valid;
  logic [7:0]             insn_byte;
  logic                   insn_abort;
  logic [15:0]            reg_ip, reg_af, reg_bc, reg_de, reg_hl, reg_ix, reg_iy, reg_sp;
  logic                   z80fi_valid;
  logic [8*MAX_LEN-1:0]   z80fi_insn;
  logic [2:0]             z80fi_insn_len;
  logic                   z80fi_insn_err;
  logic [15:0]            z80fi_reg_ip_in, z80fi_reg_ip_out;
  logic [15:0]            z80fi_reg_af_in, z80fi_reg_af_out;
  logic [15:0]            z80fi_reg_bc_in, z80fi_reg_bc_out;
  logic [15:0]            z80fi_reg_de_in, z80fi_reg_de_out;
  logic [15:0]            z80fi_reg_hl_in, z80fi_reg_hl_out;
  logic [15:0]            z80fi_reg_ix_in, z80fi_reg_ix_out;
  logic [15:0]            z80fi_reg_iy_in, z80fi_reg_iy_out;
  logic [15:0]            z80fi_reg_sp_in, z80fi_reg_sp_out;
`ifdef Z80FI_PACKER_ALT_REGS_EN
  logic [15:0]            reg_af2, reg_bc2, reg_de2, reg_hl2;
  logic [15:0]            z80fi_reg_af2_in, z80fi_reg_af2_out;
  logic [15:0]            z80fi_reg_bc2_in, z80fi_reg_bc2_out;
  logic [15:0]            z80fi_reg_de2_in, z80fi_reg_de2_out;
  logic [15:0]            z80fi_reg_hl2_in, z80fi_reg_hl2_out;
`endif

  modport master (
`ifdef Z80FI_PACKER_ALT_REGS_EN
    output reg_af2, reg_bc2, reg_de2, reg_hl2,
    input  z80fi_reg_af2_in, z80fi_reg_af2_out, z80fi_reg_bc2_in, z80fi_reg_bc2_out,
    input  z80fi_reg_de2_in, z80fi_reg_de2_out, z80fi_reg_hl2_in, z80fi_reg_hl2_out,
`endif
    output insn_start, insn_byte_valid, insn_byte, insn_abort,
    output reg_ip, reg_af, reg_bc, reg_de, reg_hl, reg_ix, reg_iy, reg_sp,
    input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_insn_err,
    input  z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_af_in, z80fi_reg_af_out,
    input  z80fi_reg_bc_in, z80fi_reg_bc_out, z80fi_reg_de_in, z80fi_reg_de_out,
    input  z80fi_reg_hl_in, z80fi_reg_hl_out, z80fi_reg_ix_in, z80fi_reg_ix_out,
    input  z80fi_reg_iy_in, z80fi_reg_iy_out, z80fi_reg_sp_in, z80fi_reg_sp_out
  );

  modport slave (
`ifdef Z80FI_PACKER_ALT_REGS_EN
    input  reg_af2, reg_bc2, reg_de2, reg_hl2,
    output z80fi_reg_af2_in, z80fi_reg_af2_out, z80fi_reg_bc2_in, z80fi_reg_bc2_out,
    output z80fi_reg_de2_in, z80fi_reg_de2_out, z80fi_reg_hl2_in, z80fi_reg_hl2_out,
`endif
    input  insn_start, insn_byte_valid, insn_byte, insn_abort,
    input  reg_ip, reg_af, reg_bc, reg_de, reg_hl, reg_ix, reg_iy, reg_sp,
    output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_insn_err,
    output z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_af_in, z80fi_reg_af_out,
    output z80fi_reg_bc_in, z80fi_reg_bc_out, z80fi_reg_de_in, z80fi_reg_de_out,
    output z80fi_reg_hl_in, z80fi_reg_hl_out, z80fi_reg_ix_in, z80fi_reg_ix_out,
    output z80fi_reg_iy_in, z80fi_reg_iy_out, z80fi_reg_sp_in, z80fi_reg_sp_out
  );
endinterface

// File: rtl/z80fi_insn_byte_collector.sv
// Opcode byte buffer for the open instruction: length counter that saturates
// at MAX_LEN and a sticky overflow flag.
module z80fi_insn_byte_collector #(
  parameter int MAX_LEN = 4,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_push,
  input  logic [7:0]           i_byte,
  output logic [8*MAX_LEN-1:0] o_buf,
  output logic [LEN_W-1:0]     o_len,
  output logic                 o_err
);

  logic [8*MAX_LEN-1:0] r_buf;
  logic [LEN_W-1:0]     r_len;
  logic                 r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf <= '0;
      r_len <= '0;
      r_err <= 1'b0;
    end else if (i_clear) begin
      // A byte pushed alongside clear is byte 0 of the new instruction
      r_buf <= '0;
      r_len <= '0;
      r_err <= 1'b0;
      if (i_push) begin
        r_buf[7:0] <= i_byte;
        r_len      <= LEN_W'(1);
      end
    end else if (i_push) begin
      if (r_len < LEN_W'(MAX_LEN)) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (r_len == LEN_W'(i)) r_buf[8*i +: 8] <= i_byte;
        end
        r_len <= r_len + LEN_W'(1);
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_buf = r_buf;
  assign o_len = r_len;
  assign o_err = r_err;

endmodule

// File: rtl/z80fi_insn_packer.sv
// Builds one z80fi retirement record per instruction boundary.
// Optional alternate register set: Z80FI_PACKER_ALT_REGS_EN.
//   state      | meaning
//   ST_IDLE    | nothing pending (after reset or abort)
//   ST_COLLECT | an instruction is open, bytes are being gathered
module z80fi_insn_packer
  import z80fi_pkg::*;
#(
  parameter int MAX_LEN = 4
) (
  input  logic         clk,
  input  logic         reset,
  z80fi_insn_packer_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  z80fi_state_t         r_state;
  z80fi_regs_t          r_in;
  z80fi_regs_t          r_rec_in;
  z80fi_regs_t          r_rec_out;
  logic                 r_valid;
  logic [8*MAX_LEN-1:0] r_insn;
  logic [2:0]           r_len;
  logic                 r_err;

  z80fi_regs_t          w_live;
  logic                 w_clear;
  logic                 w_push;
  logic [8*MAX_LEN-1:0] w_buf;
  logic [LEN_W-1:0]     w_len;
  logic                 w_err;

  always_comb begin
    w_live    = '0;
    w_live.ip = bus.reg_ip;
    w_live.af = bus.reg_af;
    w_live.bc = bus.reg_bc;
    w_live.de = bus.reg_de;
    w_live.hl = bus.reg_hl;
    w_live.ix = bus.reg_ix;
    w_live.iy = bus.reg_iy;
    w_live.sp = bus.reg_sp;
`ifdef Z80FI_PACKER_ALT_REGS_EN
    w_live.af2 = bus.reg_af2;
    w_live.bc2 = bus.reg_bc2;
    w_live.de2 = bus.reg_de2;
    w_live.hl2 = bus.reg_hl2;
`endif
  end

  // Abort beats start: no new instruction opens and no bytes are taken
  assign w_clear = bus.insn_start & ~bus.insn_abort;
  assign w_push  = bus.insn_byte_valid & ~bus.insn_abort &
                   (w_clear | (r_state == ST_COLLECT));

  z80fi_insn_byte_collector #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_collector (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_byte  (bus.insn_byte),
    .o_buf   (w_buf),
    .o_len   (w_len),
    .o_err   (w_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_in      <= '0;
      r_rec_in  <= '0;
      r_rec_out <= '0;
      r_valid   <= 1'b0;
      r_insn    <= '0;
      r_len     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.insn_abort) begin
        r_state <= ST_IDLE;
      end else if (bus.insn_start) begin
        if (r_state == ST_COLLECT) begin
          r_valid   <= 1'b1;
          r_insn    <= w_buf;
          r_len     <= 3'(w_len);
          r_err     <= w_err;
          r_rec_in  <= r_in;
          r_rec_out <= w_live;
        end
        r_in    <= w_live;
        r_state <= ST_COLLECT;
      end
    end
  end

  assign bus.z80fi_valid      = r_valid;
  assign bus.z80fi_insn       = r_insn;
  assign bus.z80fi_insn_len   = r_len;
  assign bus.z80fi_insn_err   = r_err;
  assign bus.z80fi_reg_ip_in  = r_rec_in.ip;
  assign bus.z80fi_reg_ip_out = r_rec_out.ip;
  assign bus.z80fi_reg_af_in  = r_rec_in.af;
  assign bus.z80fi_reg_af_out = r_rec_out.af;
  assign bus.z80fi_reg_bc_in  = r_rec_in.bc;
  assign bus.z80fi_reg_bc_out = r_rec_out.bc;
  assign bus.z80fi_reg_de_in  = r_rec_in.de;
  assign bus.z80fi_reg_de_out = r_rec_out.de;
  assign bus.z80fi_reg_hl_in  = r_rec_in.hl;
  assign bus.z80fi_reg_hl_out = r_rec_out.hl;
  assign bus.z80fi_reg_ix_in  = r_rec_in.ix;
  assign bus.z80fi_reg_ix_out = r_rec_out.ix;
  assign bus.z80fi_reg_iy_in  = r_rec_in.iy;
  assign bus.z80fi_reg_iy_out = r_rec_out.iy;
  assign bus.z80fi_reg_sp_in  = r_rec_in.sp;
  assign bus.z80fi_reg_sp_out = r_rec_out.sp;
`ifdef Z80FI_PACKER_ALT_REGS_EN
  assign bus.z80fi_reg_af2_in  = r_rec_in.af2;
  assign bus.z80fi_reg_af2_out = r_rec_out.af2;
  assign bus.z80fi_reg_bc2_in  = r_rec_in.bc2;
  assign bus.z80fi_reg_bc2_out = r_rec_out.bc2;
  assign bus.z80fi_reg_de2_in  = r_rec_in.de2;
  assign bus.z80fi_reg_de2_out = r_rec_out.de2;
  assign bus.z80fi_reg_hl2_in  = r_rec_in.hl2;
  assign bus.z80fi_reg_hl2_out = r_rec_out.hl2;
`endif

endmodule

// File: tb/tb_z80fi_insn_packer.sv
// Directed bench for z80fi_insn_packer (default build, MAX_LEN = 4).
// Z80FI_PACKER_ALT_REGS_EN only adds alternate-register drive here.
module tb_z80fi_insn_packer;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   pulses;
  int   p_snap;

  z80fi_insn_packer_if #(.MAX_LEN(4)) bus ();

  z80fi_insn_packer #(.MAX_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.z80fi_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic bv, input logic [7:0] b, input logic ab);
    bus.insn_start      = st;
    bus.insn_byte_valid = bv;
    bus.insn_byte       = b;
    bus.insn_abort      = ab;
    @(posedge clk);
    #1;
    bus.insn_start      = 1'b0;
    bus.insn_byte_valid = 1'b0;
    bus.insn_byte       = 8'h00;
    bus.insn_abort      = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    pulses = 0;
    reset  = 1'b1;
    bus.insn_start      = 1'b0;
    bus.insn_byte_valid = 1'b0;
    bus.insn_byte       = 8'h00;
    bus.insn_abort      = 1'b0;
    bus.reg_ip = 16'h0100; bus.reg_af = 16'h1122; bus.reg_bc = 16'h1234;
    bus.reg_de = 16'h3344; bus.reg_hl = 16'h5566; bus.reg_ix = 16'h7788;
    bus.reg_iy = 16'h99AA; bus.reg_sp = 16'hFFF0;
`ifdef Z80FI_PACKER_ALT_REGS_EN
    bus.reg_af2 = 16'hA0A0; bus.reg_bc2 = 16'hB0B0;
    bus.reg_de2 = 16'hD0D0; bus.reg_hl2 = 16'hE0E0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.z80fi_valid), 64'h0);
    chk("rst_insn", 64'(bus.z80fi_insn), 64'h0);
    chk("rst_len", 64'(bus.z80fi_insn_len), 64'h0);
    chk("rst_bc_in", 64'(bus.z80fi_reg_bc_in), 64'h0);
    reset = 1'b0;

    // INC BC
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("idle_start_no_pulse", 64'(bus.z80fi_valid), 64'h0);
    cyc(1'b0, 1'b1, 8'h03, 1'b0);
    bus.reg_bc = 16'h1235;
    bus.reg_ip = 16'h0101;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("inc_valid", 64'(bus.z80fi_valid), 64'h1);
    chk("inc_insn", 64'(bus.z80fi_insn), 64'h03);
    chk("inc_len", 64'(bus.z80fi_insn_len), 64'h1);
    chk("inc_err", 64'(bus.z80fi_insn_err), 64'h0);
    chk("inc_bc_in", 64'(bus.z80fi_reg_bc_in), 64'h1234);
    chk("inc_bc_out", 64'(bus.z80fi_reg_bc_out), 64'h1235);
    chk("inc_ip_in", 64'(bus.z80fi_reg_ip_in), 64'h0100);
    chk("inc_ip_out", 64'(bus.z80fi_reg_ip_out), 64'h0101);
    chk("inc_af_out", 64'(bus.z80fi_reg_af_out), 64'h1122);
    chk("inc_sp_in", 64'(bus.z80fi_reg_sp_in), 64'hFFF0);
    chk("inc_hl_out", 64'(bus.z80fi_reg_hl_out), 64'h5566);

    // DD 36 05 7F
    cyc(1'b0, 1'b1, 8'hDD, 1'b0);
    chk("pulse_one_cycle", 64'(bus.z80fi_valid), 64'h0);
    chk("hold_insn", 64'(bus.z80fi_insn), 64'h03);
    cyc(1'b0, 1'b1, 8'h36, 1'b0);
    cyc(1'b0, 1'b1, 8'h05, 1'b0);
    cyc(1'b0, 1'b1, 8'h7F, 1'b0);
    bus.reg_ip = 16'h0105;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("ld_valid", 64'(bus.z80fi_valid), 64'h1);
    chk("ld_insn", 64'(bus.z80fi_insn), 64'h7F0536DD);
    chk("ld_len", 64'(bus.z80fi_insn_len), 64'h4);
    chk("ld_err", 64'(bus.z80fi_insn_err), 64'h0);
    chk("ld_ip_in", 64'(bus.z80fi_reg_ip_in), 64'h0101);
    chk("ld_ip_out", 64'(bus.z80fi_reg_ip_out), 64'h0105);

    // Overflow: five bytes into a four-byte record
    for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("ovf_valid", 64'(bus.z80fi_valid), 64'h1);
    chk("ovf_len", 64'(bus.z80fi_insn_len), 64'h4);
    chk("ovf_insn", 64'(bus.z80fi_insn), 64'h04030201);
    chk("ovf_err", 64'(bus.z80fi_insn_err), 64'h1);

    // Start with byte in same cycle
    cyc(1'b0, 1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 1'b1, 8'h0B, 1'b0);
    chk("same_prior_insn", 64'(bus.z80fi_insn), 64'hAA);
    chk("same_prior_len", 64'(bus.z80fi_insn_len), 64'h1);
    chk("after_ovf_err", 64'(bus.z80fi_insn_err), 64'h0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("same_new_valid", 64'(bus.z80fi_valid), 64'h1);
    chk("same_new_insn", 64'(bus.z80fi_insn), 64'h0B);
    chk("same_new_len", 64'(bus.z80fi_insn_len), 64'h1);

    // Abort (together with start) discards the open instruction
    cyc(1'b0, 1'b1, 8'h11, 1'b0);
    cyc(1'b0, 1'b1, 8'h22, 1'b0);
    p_snap = pulses;
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("abort_valid", 64'(bus.z80fi_valid), 64'h0);
    cyc(1'b0, 1'b1, 8'h33, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h76, 1'b0);
    chk("abort_no_pulse", 64'(pulses), 64'(p_snap));
    chk("abort_hold_insn", 64'(bus.z80fi_insn), 64'h0B);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("post_abort_valid", 64'(bus.z80fi_valid), 64'h1);
    chk("post_abort_insn", 64'(bus.z80fi_insn), 64'h76);

    // Reset mid-instruction after two bytes
    cyc(1'b0, 1'b1, 8'h12, 1'b0);
    cyc(1'b0, 1'b1, 8'h34, 1'b0);
    p_snap = pulses;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.z80fi_valid), 64'h0);
    chk("mid_rst_insn", 64'(bus.z80fi_insn), 64'h0);
    chk("mid_rst_len", 64'(bus.z80fi_insn_len), 64'h0);
    chk("mid_rst_bc_out", 64'(bus.z80fi_reg_bc_out), 64'h0);
    chk("mid_rst_ip_in", 64'(bus.z80fi_reg_ip_in), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_no_pulse", 64'(pulses), 64'(p_snap));
    cyc(1'b0, 1'b1, 8'hC9, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("post_rst_valid", 64'(bus.z80fi_valid), 64'h1);
    chk("post_rst_insn", 64'(bus.z80fi_insn), 64'hC9);
    chk("post_rst_len", 64'(bus.z80fi_insn_len), 64'h1);

    // Three starts back to back from IDLE
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    bus.reg_bc = 16'h0001;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("b2b_c1_valid", 64'(bus.z80fi_valid), 64'h0);
    bus.reg_bc = 16'h0002;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("b2b_c2_valid", 64'(bus.z80fi_valid), 64'h1);
    chk("b2b_c2_len", 64'(bus.z80fi_insn_len), 64'h0);
    chk("b2b_c2_insn", 64'(bus.z80fi_insn), 64'h0);
    chk("b2b_c2_bc_in", 64'(bus.z80fi_reg_bc_in), 64'h0001);
    chk("b2b_c2_bc_out", 64'(bus.z80fi_reg_bc_out), 64'h0002);
    bus.reg_bc = 16'h0003;
    bus.reg_de = 16'h4455;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("b2b_c3_valid", 64'(bus.z80fi_valid), 64'h1);
    chk("b2b_c3_len", 64'(bus.z80fi_insn_len), 64'h0);
    chk("b2b_c3_bc_in", 64'(bus.z80fi_reg_bc_in), 64'h0002);
    chk("b2b_c3_bc_out", 64'(bus.z80fi_reg_bc_out), 64'h0003);
    chk("b2b_c3_de_in", 64'(bus.z80fi_reg_de_in), 64'h3344);
    chk("b2b_c3_de_out", 64'(bus.z80fi_reg_de_out), 64'h4455);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("b2b_c4_valid", 64'(bus.z80fi_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
